clk_gen_ctrl: RTL
=================

Name: clk_gen_ctrl

Overview:
Run/stop sequencer and clock-enable scheduler for the divided-clock datapath (4f/2f/f derived from clk_32f).
- Starts all divided clocks phase-aligned from a common 5-bit phase counter.
- Applies per-clock enable masks glitch-free, and stops cleanly at a full clk_f period boundary.
- Reports lock status and one-cycle rising-edge strobes so downstream serializer/deserializer logic can schedule on clk_32f without crossing domains.

Parameters:
LOCK_PERIODS, 1, number of complete clk_f periods (32 clk_32f cycles each) in RUN before locked asserts; legal range 1..15.

Ports:
clk_32f  input  1  sole clock; all state changes on its rising edge.
reset  input  1  synchronous reset, active-high.
start  input  1  run request; sampled only in IDLE.
stop  input  1  stop request; sampled in RUN.
en_mask  input  3  clock enables: [0]=clk_4f, [1]=clk_2f, [2]=clk_f.
clk_4f  output  1  divided clock, period 8 cycles, registered.
clk_2f  output  1  divided clock, period 16 cycles, registered.
clk_f  output  1  divided clock, period 32 cycles, registered.
stb_4f  output  1  one-cycle pulse in the cycle clk_4f rises.
stb_2f  output  1  one-cycle pulse in the cycle clk_2f rises.
stb_f  output  1  one-cycle pulse in the cycle clk_f rises.
locked  output  1  divided clocks stable for LOCK_PERIODS periods.
state  output  2  FSM state: IDLE=00, RUN=01, DRAIN=10; 11 unused.

Behaviour:
- Reset (synchronous, any state, including mid-RUN/DRAIN), next edge:
  - state=IDLE, phase counter cnt=0, en_q=000, lock counter=0.
  - All clk_*, stb_* and locked = 0.
- cnt: 5-bit counter. Increments by 1 every cycle in RUN and DRAIN, wraps 31->0. Holds 0 in IDLE.
- Divided clocks (from registered cnt and en_q):
  - clk_4f = cnt[2] & en_q[0]
  - clk_2f = cnt[3] & en_q[1]
  - clk_f = cnt[4] & en_q[2]
  - All forced 0 in IDLE.
  - Duty cycle 50%. Each output goes high 4/8/16 cycles after entering RUN.
- Strobes, each qualified by its en_q bit and state != IDLE:
  - stb_4f=1 when cnt[2:0]==100
  - stb_2f=1 when cnt[3:0]==1000
  - stb_f=1 when cnt==10000
- FSM:
  - IDLE: start=1 & stop=0 -> RUN; en_q<=en_mask, cnt stays 0. If start and stop are both 1, stop wins; remain IDLE.
  - RUN: stop=1 -> DRAIN, and locked clears the same edge. start is ignored.
  - DRAIN: keep counting. At the edge where cnt==31 -> IDLE, cnt=0. All clocks therefore end low after a complete clk_f period; no truncated high pulse. start and stop are ignored.
- en_mask updates during RUN: latched into en_q only on the wrap edge (cnt 31->0), so no output ever produces a runt pulse. en_mask is ignored in DRAIN.
- Lock counter (4-bit):
  - Increments on each wrap in RUN, saturating at LOCK_PERIODS.
  - locked=1 once count==LOCK_PERIODS while in RUN.
  - Clears on entering IDLE or DRAIN.
  - Latency with LOCK_PERIODS=1: locked rises 32 cycles after the start edge.
- en_mask=000 while running: FSM and cnt run normally, all clocks and strobes stay 0, and locked still asserts.

Test Plan:
- Reset, then start=1 for 1 cycle with en_mask=111.
  - state=01.
  - clk_4f rises after 4 cycles; clk_2f after 8; clk_f after 16.
  - stb_* pulses are exactly 1 cycle wide and coincident with each rise.
  - locked=1 at cycle 32.
- Start with en_mask=101, then change en_mask to 010 at cnt=10.
  - clk_2f stays 0 until cnt wraps.
  - From the wrap onward, only clk_2f toggles; clk_4f and clk_f remain 0.
- stop=1 at cnt=5 in RUN.
  - state=10 and locked=0 next cycle.
  - Clocks continue until cnt=31, then state=00.
  - All outputs 0; last clk_f high pulse is the full 16 cycles.
- start=1 and stop=1 together in IDLE -> state stays 00, all outputs 0. start pulsed during DRAIN -> ignored; FSM still returns to IDLE at the wrap.
- Set LOCK_PERIODS=3, start.
  - locked=0 at cycles 32 and 64; locked=1 at cycle 96.
  - Assert reset at cycle 100: next edge, all outputs 0, state=00, locked=0.
- reset asserted mid-DRAIN at cnt=20 -> next edge: cnt=0, IDLE, clocks low. A following start gives a clean first period (clk_4f rises after 4 cycles).

Source files
------------

// File: rtl/clk_gen_ctrl.sv
// Run/stop sequencer and clock-enable scheduler for the 4f/2f/f divided clocks of clk_32f.
// Every output is a flop, so downstream logic sees glitch-free clocks and strobes.
module clk_gen_ctrl #(
  parameter int unsigned LOCK_PERIODS = 1  // legal range 1..15
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] en_mask,
  output logic       clk_4f,
  output logic       clk_2f,
  output logic       clk_f,
  output logic       stb_4f,
  output logic       stb_2f,
  output logic       stb_f,
  output logic       locked,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10
  } state_e;

  localparam logic [3:0] LockTarget = 4'(LOCK_PERIODS);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] en_q, en_d;
  logic [3:0] lock_q, lock_d;
  logic       wrap;
  logic       run_d;

  logic clk_4f_d, clk_2f_d, clk_f_d;
  logic stb_4f_d, stb_2f_d, stb_f_d;
  logic locked_d;

  assign wrap = (cnt_q == 5'd31);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    lock_d  = lock_q;
    unique case (state_q)
      StIdle: begin
        cnt_d  = 5'd0;
        lock_d = 4'd0;
        // stop has priority over a simultaneous start
        if (start && !stop) begin
          state_d = StRun;
          en_d    = en_mask;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 5'd1;
        if (stop) begin
          state_d = StDrain;
          lock_d  = 4'd0;
        end else if (wrap) begin
          // enables only change at a full clk_f boundary, so no runt pulses
          en_d = en_mask;
          if (lock_q < LockTarget) begin
            lock_d = lock_q + 4'd1;
          end
        end
      end
      StDrain: begin
        cnt_d  = cnt_q + 5'd1;
        lock_d = 4'd0;
        if (wrap) begin
          state_d = StIdle;
          cnt_d   = 5'd0;
          en_d    = 3'b000;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 5'd0;
        en_d    = 3'b000;
        lock_d  = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from next-state so the flops match cnt_q/en_q in the same cycle.
  always_comb begin
    run_d    = (state_d != StIdle);
    clk_4f_d = run_d & en_d[0] & cnt_d[2];
    clk_2f_d = run_d & en_d[1] & cnt_d[3];
    clk_f_d  = run_d & en_d[2] & cnt_d[4];
    stb_4f_d = run_d & en_d[0] & (cnt_d[2:0] == 3'b100);
    stb_2f_d = run_d & en_d[1] & (cnt_d[3:0] == 4'b1000);
    stb_f_d  = run_d & en_d[2] & (cnt_d == 5'b10000);
    locked_d = (state_d == StRun) & (lock_d == LockTarget);
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      en_q    <= 3'b000;
      lock_q  <= 4'd0;
      clk_4f  <= 1'b0;
      clk_2f  <= 1'b0;
      clk_f   <= 1'b0;
      stb_4f  <= 1'b0;
      stb_2f  <= 1'b0;
      stb_f   <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      lock_q  <= lock_d;
      clk_4f  <= clk_4f_d;
      clk_2f  <= clk_2f_d;
      clk_f   <= clk_f_d;
      stb_4f  <= stb_4f_d;
      stb_2f  <= stb_2f_d;
      stb_f   <= stb_f_d;
      locked  <= locked_d;
    end
  end

  assign state = state_q;

endmodule
